// File: rtl/stream_pkg.sv
// Shared types and the ready-throttle recurrence for the stream sources and sinks.
package stream_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STALL, ST_DONE} st_e;

  localparam logic [31:0] NO_ERR_IDX = 32'hFFFF_FFFF;

  // Stall length after a beat, 3-bit wrap. A zero multiplier disables throttling entirely.
  function automatic logic [2:0] stall_next(input logic [2:0] c, input logic [2:0] cnt,
                                            input logic [2:0] v);
    logic [2:0] p;
    if (c == 3'd0) return 3'd0;
    p = c * cnt;
    return p + v;
  endfunction

endpackage

// File: rtl/stream_check_sink_if.sv
// Valid/ready stream carrying one 32-bit word per beat.
interface stream_check_sink_if;
  logic [31:0] val;
  logic        valid;
  logic        ready;

  modport master (output val, output valid, input ready);
  modport slave  (input val, input valid, output ready);
endinterface

// File: rtl/stream_exp_mem.sv
// Expected-value store: one synchronous write port, one asynchronous read port.
module stream_exp_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/stream_check_sink.sv
// Self-checking stream consumer: throttles ready, compares beats to an expected
// memory and reports error count, first failing index and pass.
module stream_check_sink
  import stream_pkg::*;
#(
  parameter logic [2:0] C     = 3'd3,
  parameter int         DEPTH = 1024,
  parameter int         AW    = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  stream_check_sink_if.slave  stream,
  input  logic [31:0]         n,
  input  logic                start,
  output logic                finish,
  input  logic                exp_we,
  input  logic [AW-1:0]       exp_addr,
  input  logic [31:0]         exp_data,
  output logic [31:0]         err_cnt,
  output logic [31:0]         first_err_idx,
  output logic                pass
);

  st_e         state, state_nxt;
  logic        start_reg, start_edge;
  logic        ready_c, last, mismatch;
  logic [31:0] idx, n_reg, exp_word;
  logic [2:0]  cnt, stall;

  stream_exp_mem #(.DEPTH(DEPTH), .AW(AW)) u_exp_mem (
    .clk   (clk),
    .we    (exp_we),
    .waddr (exp_addr),
    .wdata (exp_data),
    .raddr (idx[AW-1:0]),
    .rdata (exp_word)
  );

  assign start_edge   = start && !start_reg;
  assign last         = (idx + 32'd1) == n_reg;
  assign mismatch     = stream.val != exp_word;
  assign stall        = stall_next(C, cnt, stream.val[2:0]);
  assign stream.ready = ready_c;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_RUN: begin
        ready_c = 1'b1;
        if (stream.valid)
          state_nxt = last ? ST_DONE : ((stall == 3'd0) ? ST_RUN : ST_STALL);
      end
      ST_STALL: if (cnt == 3'd0) state_nxt = ST_RUN;
      ST_DONE: ;
      default: state_nxt = ST_IDLE;
    endcase
    // A new run overrides anything else happening this cycle, including a beat.
    if (start_edge) state_nxt = (n == 32'd0) ? ST_DONE : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_reg     <= 1'b0;
      n_reg         <= '0;
      idx           <= '0;
      cnt           <= '0;
      err_cnt       <= '0;
      first_err_idx <= NO_ERR_IDX;
      finish        <= 1'b0;
      pass          <= 1'b0;
    end else begin
      start_reg <= start;
      if (start_edge) begin
        n_reg         <= n;
        idx           <= '0;
        cnt           <= '0;
        err_cnt       <= '0;
        first_err_idx <= NO_ERR_IDX;
        finish        <= 1'b0;
        pass          <= 1'b0;
      end else begin
        case (state)
          ST_RUN: if (stream.valid) begin
            if (mismatch) begin
              if (err_cnt != 32'hFFFF_FFFF) err_cnt <= err_cnt + 32'd1;
              if (first_err_idx == NO_ERR_IDX) first_err_idx <= idx;
            end
            idx <= idx + 32'd1;
            cnt <= (last || stall == 3'd0) ? 3'd0 : stall - 3'd1;
          end
          ST_STALL: if (cnt != 3'd0) cnt <= cnt - 3'd1;
          ST_DONE: begin
            finish <= 1'b1;
            pass   <= (err_cnt == 32'd0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_check_sink.sv
// Directed bench for stream_check_sink: one unthrottled (C=0) and one throttled (C=3)
// instance, each tracked by a beat-level reference model compared every cycle.
module tb_stream_check_sink;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]   val_d [2];
  logic          valid_d [2];
  logic          start_d [2];
  logic [31:0]   n_d [2];
  logic          exp_we [2];
  logic [AW-1:0] exp_addr [2];
  logic [31:0]   exp_data [2];
  logic          rdy [2];
  logic          fin [2];
  logic          pass_o [2];
  logic [31:0]   err_o [2];
  logic [31:0]   first_o [2];

  stream_check_sink_if sif0 ();
  stream_check_sink_if sif3 ();
  assign sif0.val   = val_d[0];
  assign sif0.valid = valid_d[0];
  assign rdy[0]     = sif0.ready;
  assign sif3.val   = val_d[1];
  assign sif3.valid = valid_d[1];
  assign rdy[1]     = sif3.ready;

  stream_check_sink #(.C(3'd0), .DEPTH(DEPTH), .AW(AW)) dut0 (
    .clk(clk), .reset_n(reset_n), .stream(sif0), .n(n_d[0]), .start(start_d[0]),
    .finish(fin[0]), .exp_we(exp_we[0]), .exp_addr(exp_addr[0]), .exp_data(exp_data[0]),
    .err_cnt(err_o[0]), .first_err_idx(first_o[0]), .pass(pass_o[0]));

  stream_check_sink #(.C(3'd3), .DEPTH(DEPTH), .AW(AW)) dut3 (
    .clk(clk), .reset_n(reset_n), .stream(sif3), .n(n_d[1]), .start(start_d[1]),
    .finish(fin[1]), .exp_we(exp_we[1]), .exp_addr(exp_addr[1]), .exp_data(exp_data[1]),
    .err_cnt(err_o[1]), .first_err_idx(first_o[1]), .pass(pass_o[1]));

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: tracks beats accepted, remaining stall cycles and run outcome.
  bit          m_run [2];
  bit          m_done [2];
  bit          m_sp [2];
  bit          m_fin [2];
  bit          m_pass [2];
  int          m_stall [2];
  int          m_cnt [2];
  int          m_beats [2];
  int          m_n [2];
  logic [31:0] m_err [2];
  logic [31:0] m_first [2];
  logic [31:0] m_exp [2][DEPTH];

  function automatic int cval(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  function automatic bit m_rdy(input int k);
    return m_run[k] && (m_stall[k] == 0);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        m_run[k] = 1'b0; m_done[k] = 1'b0; m_sp[k] = 1'b0; m_fin[k] = 1'b0; m_pass[k] = 1'b0;
        m_stall[k] = 0; m_cnt[k] = 0; m_beats[k] = 0; m_n[k] = 0;
        m_err[k] = 32'd0; m_first[k] = 32'hFFFF_FFFF;
      end else begin
        if (start_d[k] && !m_sp[k]) begin
          m_n[k] = int'(n_d[k]); m_beats[k] = 0; m_stall[k] = 0; m_cnt[k] = 0;
          m_err[k] = 32'd0; m_first[k] = 32'hFFFF_FFFF; m_fin[k] = 1'b0; m_pass[k] = 1'b0;
          m_done[k] = (n_d[k] == 32'd0);
          m_run[k]  = (n_d[k] != 32'd0);
        end else if (m_done[k]) begin
          m_fin[k]  = 1'b1;
          m_pass[k] = (m_err[k] == 32'd0);
        end else if (m_run[k] && m_stall[k] != 0) begin
          m_stall[k] = m_stall[k] - 1;
        end else if (m_run[k] && valid_d[k]) begin
          if (val_d[k] !== m_exp[k][m_beats[k] % DEPTH]) begin
            if (m_err[k] != 32'hFFFF_FFFF) m_err[k] = m_err[k] + 32'd1;
            if (m_first[k] == 32'hFFFF_FFFF) m_first[k] = 32'(m_beats[k]);
          end
          m_beats[k] = m_beats[k] + 1;
          if (m_beats[k] == m_n[k]) begin
            m_run[k]  = 1'b0;
            m_done[k] = 1'b1;
          end else begin
            m_stall[k] = (cval(k) == 0) ? 0 : (cval(k) * m_cnt[k] + int'(val_d[k][2:0])) % 8;
            m_cnt[k]   = 0;
          end
        end
        m_sp[k] = start_d[k];
      end
      if (exp_we[k]) m_exp[k][exp_addr[k]] = exp_data[k];
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk("ready", k, 32'(rdy[k]), 32'(m_rdy(k)));
        chk("finish", k, 32'(fin[k]), 32'(m_fin[k]));
        chk("pass", k, 32'(pass_o[k]), 32'(m_pass[k]));
        chk("err_cnt", k, err_o[k], m_err[k]);
        chk("first_err_idx", k, first_o[k], m_first[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int k, input int base);
    for (int i = 0; i < 32; i++) begin
      exp_we[k] = 1'b1; exp_addr[k] = AW'(i); exp_data[k] = 32'(base + i);
      tick();
    end
    exp_we[k] = 1'b0;
  endtask

  task automatic start_run(input int k, input int nn);
    n_d[k] = 32'(nn);
    start_d[k] = 1'b1;
    tick();
    start_d[k] = 1'b0;
  endtask

  function automatic logic [31:0] beat_val(input int base, input int b, input int ba, input int bb);
    logic [31:0] v;
    v = 32'(base + b);
    if (b == ba || b == bb) v = v ^ 32'd1;
    return v;
  endfunction

  int gap [64];

  // Producer: valid held high, advances one word per accepted beat.
  task automatic run_beats(input int k, input int cnt, input int base, input int ba, input int bb,
                           output int cycles);
    int b;
    bit x;
    b = 0;
    cycles = 0;
    for (int i = 0; i < 64; i++) gap[i] = 0;
    valid_d[k] = 1'b1;
    val_d[k] = beat_val(base, 0, ba, bb);
    while (b < cnt && cycles < 300) begin
      @(negedge clk);
      x = rdy[k];
      if (!x && b > 0) gap[b-1]++;
      tick();
      cycles++;
      if (x) begin
        b++;
        val_d[k] = beat_val(base, b, ba, bb);
      end
    end
    if (b < cnt) chk("beat_timeout", k, 32'(b), 32'(cnt));
  endtask

  task automatic chk_outs(input string nm, input int k, input bit f, input bit p,
                          input logic [31:0] e, input logic [31:0] fi);
    chk({nm, "_finish"}, k, 32'(fin[k]), 32'(f));
    chk({nm, "_pass"}, k, 32'(pass_o[k]), 32'(p));
    chk({nm, "_err"}, k, err_o[k], e);
    chk({nm, "_first"}, k, first_o[k], fi);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    for (int k = 0; k < 2; k++) begin
      val_d[k] = '0; valid_d[k] = 1'b0; start_d[k] = 1'b0; n_d[k] = '0;
      exp_we[k] = 1'b0; exp_addr[k] = '0; exp_data[k] = '0; m_first[k] = 32'hFFFF_FFFF;
    end
    reset_n = 1'b0;
    tick();
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_ready", 0, 32'(rdy[0]), 32'd0);
    chk_outs("rst", 0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
    tick();
    reset_n = 1'b1;

    load(0, 0);
    load(1, 5);

    // Clean 20-beat run, no throttling.
    start_run(0, 20);
    run_beats(0, 20, 0, -1, -1, cyc);
    valid_d[0] = 1'b0;
    chk("a_cycles", 0, 32'(cyc), 32'd20);
    @(negedge clk);
    chk("a_fin_early", 0, 32'(fin[0]), 32'd0);
    tick();
    @(negedge clk);
    chk_outs("a", 0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);

    // Corrupted beats 5 and 12.
    start_run(0, 20);
    run_beats(0, 20, 0, 5, 12, cyc);
    valid_d[0] = 1'b0;
    tick();
    @(negedge clk);
    chk_outs("b", 0, 1'b1, 1'b0, 32'd2, 32'd5);

    // Throttled: values 5..14 give stalls 5,6,7,0,1,2,3,4,5 between beats.
    start_run(1, 10);
    run_beats(1, 10, 5, -1, -1, cyc);
    valid_d[1] = 1'b0;
    chk("c_gap0", 1, 32'(gap[0]), 32'd5);
    chk("c_gap1", 1, 32'(gap[1]), 32'd6);
    chk("c_gap3", 1, 32'(gap[3]), 32'd0);
    chk("c_cycles", 1, 32'(cyc), 32'd43);
    tick();
    @(negedge clk);
    chk_outs("c", 1, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);

    // Zero-length run.
    start_run(0, 0);
    @(negedge clk);
    chk("d_ready", 0, 32'(rdy[0]), 32'd0);
    chk("d_fin_early", 0, 32'(fin[0]), 32'd0);
    tick();
    @(negedge clk);
    chk_outs("d", 0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);

    // Restart on beat 7 with a simultaneous handshake; new run corrupts beat 3.
    start_run(0, 20);
    run_beats(0, 7, 0, -1, -1, cyc);
    start_d[0] = 1'b1;
    tick();
    start_d[0] = 1'b0;
    run_beats(0, 20, 0, 3, -1, cyc);
    valid_d[0] = 1'b0;
    chk("e_cycles", 0, 32'(cyc), 32'd20);
    tick();
    @(negedge clk);
    chk_outs("e", 0, 1'b1, 1'b0, 32'd1, 32'd3);

    // One-cycle reset mid-run, then a clean run proves the memory survived.
    start_run(0, 20);
    run_beats(0, 6, 0, -1, -1, cyc);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("f_ready", 0, 32'(rdy[0]), 32'd0);
    chk_outs("f_rst", 0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF);
    tick(); tick(); tick();
    valid_d[0] = 1'b0;
    start_run(0, 20);
    run_beats(0, 20, 0, -1, -1, cyc);
    valid_d[0] = 1'b0;
    tick();
    @(negedge clk);
    chk_outs("f", 0, 1'b1, 1'b1, 32'd0, 32'hFFFF_FFFF);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
